// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encoding, default widths and limits for the memory bus arbiter.
package core_bus_pkg;

    localparam int MAX_MASTERS    = 4;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bus_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side bundles of the memory bus arbiter.
interface mem_bus_arbiter_if
    import core_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W
);
    logic [NUM_MASTERS-1:0]          req_valid;
    logic [NUM_MASTERS-1:0]          req_ready;
    logic [NUM_MASTERS-1:0]          req_we;
    logic [NUM_MASTERS*ADDR_W-1:0]   req_addr;
    logic [NUM_MASTERS*DATA_W-1:0]   req_wdata;
    logic [NUM_MASTERS*DATA_W/8-1:0] req_wstrb;
    logic [NUM_MASTERS-1:0]          rsp_valid;
    logic [DATA_W-1:0]               rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

interface mem_port_if
    import core_bus_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
module rr_arbiter
    import core_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_MASTERS);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory among NUM_MASTERS requesters with round-robin
// arbitration, one outstanding transaction, and responses routed to the issuer.
module mem_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input logic              clk,
    input logic              rst_n,
    mem_bus_arbiter_if.slave req_if,
    mem_port_if.master       mem_if
);

    localparam int IDX_W  = idx_width(NUM_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    bus_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_MASTERS-1:0] owner_onehot;

    logic                   own_we;
    logic [ADDR_W-1:0]      own_addr;
    logic [DATA_W-1:0]      own_wdata;
    logic [STRB_W-1:0]      own_wstrb;

    logic [NUM_MASTERS-1:0] req_ready;
    logic [NUM_MASTERS-1:0] rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   mem_req_valid;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [STRB_W-1:0]      mem_wstrb;

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr (
        .req_i       (req_if.req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign owner_onehot = NUM_MASTERS'(1) << owner_q;
    assign own_we       = req_if.req_we[owner_q];
    assign own_addr     = req_if.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    assign own_wdata    = req_if.req_wdata[int'(owner_q)*DATA_W +: DATA_W];
    assign own_wstrb    = req_if.req_wstrb[int'(owner_q)*STRB_W +: STRB_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Owner is captured only in IDLE, so the grant stays locked through ISSUE and WAIT.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;

        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_we        = own_we;
                mem_addr      = own_addr;
                mem_wdata     = own_wdata;
                mem_wstrb     = own_wstrb;
                if (mem_if.mem_req_ready) begin
                    req_ready = owner_onehot;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mem_if.mem_rsp_valid) begin
                    rsp_valid = owner_onehot;
                    rsp_rdata = mem_if.mem_rdata;
                    rr_ptr_d  = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle must not leak a handshake or a stale response.
        if (!rst_n) begin
            req_ready     = '0;
            rsp_valid     = '0;
            rsp_rdata     = '0;
            mem_req_valid = 1'b0;
            mem_we        = 1'b0;
            mem_addr      = '0;
            mem_wdata     = '0;
            mem_wstrb     = '0;
        end
    end

    assign req_if.req_ready     = req_ready;
    assign req_if.rsp_valid     = rsp_valid;
    assign req_if.rsp_rdata     = rsp_rdata;
    assign mem_if.mem_req_valid = mem_req_valid;
    assign mem_if.mem_we        = mem_we;
    assign mem_if.mem_addr      = mem_addr;
    assign mem_if.mem_wdata     = mem_wdata;
    assign mem_if.mem_wstrb     = mem_wstrb;

endmodule
